// File: rtl/encoder_frame_pkg.sv
// Shared definitions for the absolute-encoder frame emulator: frame geometry,
// serialiser states, the holding-register word and the frame builder.
package encoder_frame_pkg;
  localparam int FRAME_W = 24;
  localparam int POS_W   = 19;
  localparam int POS_LSB = 3;

  typedef enum logic [1:0] {IDLE, START, DATA, GAP} state_e;

  typedef struct packed {
    logic             err;
    logic             warn;
    logic [POS_W-1:0] pos;
  } load_word_t;

  // Even parity in bit 0, so that the XOR of all 24 bits is zero.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [POS_W-1:0] pos,
                                                     input logic err, input logic warn);
    logic [FRAME_W-1:0] f;
    f = '0;
    f[FRAME_W-1]          = err;
    f[FRAME_W-2]          = warn;
    f[POS_LSB +: POS_W]   = pos;
    f[0]                  = ^f[FRAME_W-1:1];
    return f;
  endfunction
endpackage

// File: rtl/encoder_sck_gen.sv
// Free-running serial clock: toggles sck every CLK_DIV clk and flags the clk
// in which sck is registered from 1 to 0.
module encoder_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic sck_o,
  output logic fall_evt_o
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_q, div_d;
  logic          sck_q, sck_d;
  logic          tc;

  assign tc = (div_q == DW'(CLK_DIV - 1));

  always_comb begin
    div_d = tc ? '0 : div_q + 1'b1;
    sck_d = tc ? ~sck_q : sck_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q <= '0;
      sck_q <= 1'b1;
    end else begin
      div_q <= div_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o      = sck_q;
  assign fall_evt_o = tc & sck_q;
endmodule

// File: rtl/encoder_frame_tx.sv
// Absolute-encoder emulator: one-deep load buffer feeding a start-bit + 24-bit
// MSB-first serialiser; miso only moves on sck falling edges.
module encoder_frame_tx #(
  parameter int CLK_DIV  = 4,
  parameter int GAP_BITS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_valid_i,
  output logic        load_ready_o,
  input  logic [18:0] load_pos_i,
  input  logic        load_err_i,
  input  logic        load_warn_i,
  output logic        sck_o,
  output logic        miso_o,
  output logic        busy_o,
  output logic        frame_done_o
);
  import encoder_frame_pkg::*;

  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [4:0]         bitcnt_q, bitcnt_d;
  logic [GW-1:0]      gapcnt_q, gapcnt_d;
  load_word_t         hold_q, hold_d;
  logic               hold_vld_q, hold_vld_d;
  logic               miso_q, miso_d;
  logic               fd_q, fd_d;
  logic               fall_evt;

  encoder_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .sck_o      (sck_o),
    .fall_evt_o (fall_evt)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bitcnt_d   = bitcnt_q;
    gapcnt_d   = gapcnt_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    miso_d     = miso_q;
    fd_d       = 1'b0;

    if (load_valid_i && !hold_vld_q) begin
      hold_d     = '{err: load_err_i, warn: load_warn_i, pos: load_pos_i};
      hold_vld_d = 1'b1;
    end

    // Launch needs a full holding register and load needs an empty one, so they never collide.
    if (fall_evt) begin
      unique case (state_q)
        IDLE: if (hold_vld_q) begin
          shift_d    = build_frame(hold_q.pos, hold_q.err, hold_q.warn);
          hold_vld_d = 1'b0;
          miso_d     = 1'b0;
          state_d    = START;
        end
        START: begin
          miso_d   = shift_q[FRAME_W-1];
          bitcnt_d = 5'(FRAME_W - 1);
          state_d  = DATA;
        end
        DATA: begin
          if (bitcnt_q == '0) begin
            miso_d   = 1'b1;
            fd_d     = 1'b1;
            gapcnt_d = GW'(GAP_BITS - 1);
            state_d  = GAP;
          end else begin
            // The bit on the wire sits in the MSB; expose the next one and shift.
            miso_d   = shift_q[FRAME_W-2];
            shift_d  = {shift_q[FRAME_W-2:0], 1'b0};
            bitcnt_d = bitcnt_q - 1'b1;
          end
        end
        GAP: begin
          miso_d = 1'b1;
          if (gapcnt_q == '0) state_d = IDLE;
          else                gapcnt_d = gapcnt_q - 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bitcnt_q   <= '0;
      gapcnt_q   <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      miso_q     <= 1'b1;
      fd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bitcnt_q   <= bitcnt_d;
      gapcnt_q   <= gapcnt_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      miso_q     <= miso_d;
      fd_q       <= fd_d;
    end
  end

  assign load_ready_o = ~hold_vld_q;
  assign miso_o       = miso_q;
  assign busy_o       = (state_q != IDLE);
  assign frame_done_o = fd_q;
endmodule
